ifu_fetch_ctrl: RTL and testbench
=================================

# ifu_fetch_ctrl

Instruction-fetch sequencer for the NPC core. It owns the program counter and issues one word-aligned fetch at a time to the instruction memory over a valid/ready request and a valid response. It presents each fetched instruction, with its PC, to decode through a valid/ready handshake. Branch and jump redirects re-steer it, and any response already in flight for the old path is discarded.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  allow new fetches; low finishes the current transaction, then idles.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_resp_valid  in  1  response word valid (at most one per accepted request).
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_pc  out  32  PC of the presented instruction.
- inst_data  out  32  presented instruction word.
- redirect_valid  in  1  redirect the PC (branch, jump or trap).
- redirect_pc  in  32  new PC.
- fetch_fault  out  1  sticky flag: a misaligned redirect was received.
- fetch_count  out  32  number of instructions delivered to decode.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD, FAULT.
- Outputs decoded from state:
  - imem_req_valid = (state==REQ)
  - inst_valid = (state==HOLD)
  - fetch_fault = (state==FAULT)
- IDLE: go to REQ when fetch_en=1.
- REQ: when imem_req_ready=1, go to WAIT.
- WAIT: when imem_resp_valid=1, capture inst_data<=imem_resp_data and inst_pc<=pc, then go to HOLD.
- HOLD: when inst_ready=1:
  - fetch_count+=1 and pc<=pc+4;
  - go to REQ if fetch_en=1, else IDLE.
- DRAIN: wait for imem_resp_valid, discard the data, then go to REQ (or IDLE if fetch_en=0).
- Priority is rst, then misaligned redirect, then redirect, then normal flow.
- Redirect with redirect_pc[1:0]==0 loads pc<=redirect_pc. The next state depends on the current state:
  - IDLE: stay in IDLE.
  - REQ with imem_req_ready=0: stay in REQ; the address changes next cycle (request abandoned).
  - REQ with imem_req_ready=1: go to DRAIN, because the old request was accepted.
  - WAIT with imem_resp_valid=0: go to DRAIN.
  - WAIT with imem_resp_valid=1: drop the response and go to REQ.
  - DRAIN: update pc and stay in DRAIN (a response is still pending).
  - HOLD: drop the instruction and go to REQ. If inst_ready=1 in the same cycle, the instruction counts as delivered (fetch_count+=1), but pc takes redirect_pc, not pc+4.
- Redirect with redirect_pc[1:0]!=0 goes to FAULT from any state; pc is unchanged.
- FAULT: all inputs are ignored and no requests are issued; only rst leaves it.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_count wraps modulo 2^32.
- At most one outstanding memory request at any time.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC;
  - inst_pc=0, inst_data=0, fetch_count=0;
  - imem_req_valid=0, inst_valid=0, fetch_fault=0.
- rst asserted mid-transaction aborts immediately. A response arriving after reset is ignored, since IDLE does not sample imem_resp_valid.
- Latency with fetch_en=1 from reset release, ready always 1 and response one cycle after acceptance:
  - cycle 0: IDLE.
  - cycle 1: REQ.
  - cycle 2: WAIT, response arrives.
  - cycle 3: HOLD, inst_valid=1.
- Throughput: one instruction per 3 cycles when inst_ready=1 in HOLD.
- Handshake stability:
  - imem_req_addr is stable while imem_req_valid=1 and ready=0, except on redirect.
  - inst_pc and inst_data are stable while inst_valid=1 and inst_ready=0.
- Redirect takes effect on the next edge: a request issued in the cycle after a redirect uses the new PC.

## Test plan
- Reset then fetch_en=1, memory always ready, 1-cycle response -> requests at 8000_0000, 8000_0004, 8000_0008. Each presented in HOLD with matching inst_pc/inst_data; fetch_count=3 after three handshakes.
- Back-pressure: inst_ready=0 for 5 cycles in HOLD, then imem_req_ready=0 for 4 cycles in REQ -> outputs held stable, no duplicate or lost instruction, no second request issued.
- Redirect to 8000_0100 in WAIT, with the stale response arriving 2 cycles later -> stale word never presented; next request address is 8000_0100.
- Redirect to 8000_0040 in HOLD together with inst_ready=1 -> fetch_count increments; next request is 8000_0040, not pc+4.
- Misaligned redirect 8000_0102 -> fetch_fault=1 next cycle and stays 1; no further imem_req_valid. rst clears fault and restores pc=8000_0000.
- Wrap and halt:
  - redirect to FFFF_FFFC, deliver it -> next request address is 0000_0000;
  - fetch_en=0 during WAIT -> the instruction is still delivered, then IDLE with no new request.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one word-aligned fetch at a time,
// presents each fetched word to decode, and discards in-flight responses after a redirect.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        req_valid_q, inst_valid_q, fault_q;

  logic redir_ok, redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    inst_pc_d     = inst_pc_q;
    inst_data_d   = inst_data_q;
    fetch_count_d = fetch_count_q;

    if (state_q != FAULT && redir_bad) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redir_ok)      pc_d    = redirect_pc;
          else if (fetch_en) state_d = REQ;
        end
        REQ: begin
          if (redir_ok) begin
            pc_d    = redirect_pc;
            // An accepted request still owes us a response that must be swallowed.
            state_d = imem_req_ready ? DRAIN : REQ;
          end else if (imem_req_ready) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (redir_ok) begin
            pc_d    = redirect_pc;
            state_d = imem_resp_valid ? REQ : DRAIN;
          end else if (imem_resp_valid) begin
            inst_data_d = imem_resp_data;
            inst_pc_d   = pc_q;
            state_d     = HOLD;
          end
        end
        DRAIN: begin
          if (redir_ok)        pc_d    = redirect_pc;
          if (imem_resp_valid) state_d = fetch_en ? REQ : IDLE;
        end
        HOLD: begin
          if (inst_ready) fetch_count_d = fetch_count_q + 32'd1;
          if (redir_ok) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else if (inst_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = fetch_en ? REQ : IDLE;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_pc_q     <= '0;
      inst_data_q   <= '0;
      fetch_count_q <= '0;
      req_valid_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_pc_q     <= inst_pc_d;
      inst_data_q   <= inst_data_d;
      fetch_count_q <= fetch_count_d;
      req_valid_q   <= (state_d == REQ);
      inst_valid_q  <= (state_d == HOLD);
      fault_q       <= (state_d == FAULT);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_pc        = inst_pc_q;
  assign inst_data      = inst_data_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: a memory/decode responder with a scoreboard of expected
// request addresses and delivered instructions, driven through directed scenarios.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  ifu_fetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_inst_q[$];

  bit          ready_en      = 1'b1;
  bit          inst_ready_en = 1'b1;
  int          resp_delay    = 1;
  int          pend_cnt      = 0;
  logic [31:0] pend_addr     = '0;
  int          n_acc         = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A00;
  endfunction

  // Memory and decode responder plus scoreboard, acting just after each falling edge.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    forever begin
      logic [31:0] e;
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        pend_cnt = 0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
        end
      end
      imem_req_ready = ready_en;
      inst_ready     = inst_ready_en;
      if (imem_req_valid && imem_req_ready) begin
        n_acc++;
        pend_cnt  = resp_delay;
        pend_addr = imem_req_addr;
        check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) begin
          e = exp_req_q.pop_front();
          check("req_addr", imem_req_addr, e);
        end
      end
      if (inst_valid && inst_ready) begin
        check("inst_expected", 32'(exp_inst_q.size() != 0), 32'd1);
        if (exp_inst_q.size() != 0) begin
          e = exp_inst_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst_data, mem_word(e));
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (n_acc >= target) break;
    end
    check("tmo_accept", 32'(n_acc >= target), 32'd1);
  endtask

  task automatic wait_inst_valid();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_valid) break;
    end
    check("tmo_inst_valid", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_pc", imem_req_addr, 32'h8000_0000);

    // Sequential fetch with latency/throughput, halted during the last WAIT
    for (int i = 0; i < 3; i++) begin
      exp_req_q.push_back(32'h8000_0000 + 32'(4 * i));
      exp_inst_q.push_back(32'h8000_0000 + 32'(4 * i));
    end
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b1;
    @(posedge clk); #1;
    check("lat_c1_req", 32'(imem_req_valid), 32'd1);
    @(posedge clk); #1;
    check("lat_c2_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_c3_hold", 32'(inst_valid), 32'd1);
    wait_acc(3);
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    check("seq_count", fetch_count, 32'd3);
    check("seq_idle", 32'(imem_req_valid), 32'd0);

    // Back-pressure from decode, then from memory
    exp_req_q.push_back(32'h8000_000C);
    exp_inst_q.push_back(32'h8000_000C);
    inst_ready_en = 1'b0; fetch_en = 1'b1;
    wait_inst_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_inst_valid", 32'(inst_valid), 32'd1);
      check("bp_inst_pc", inst_pc, 32'h8000_000C);
      check("bp_inst_data", inst_data, mem_word(32'h8000_000C));
    end
    exp_req_q.push_back(32'h8000_0010);
    exp_inst_q.push_back(32'h8000_0010);
    ready_en = 1'b0; inst_ready_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_req_valid", 32'(imem_req_valid), 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h8000_0010);
    end
    ready_en = 1'b1; fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    check("bp_count", fetch_count, 32'd5);

    // Redirect during WAIT with a late stale response, then redirect in HOLD
    resp_delay = 3;
    exp_req_q.push_back(32'h8000_0014);
    exp_req_q.push_back(32'h8000_0100);
    exp_inst_q.push_back(32'h8000_0100);
    fetch_en = 1'b1;
    base = n_acc;
    wait_acc(base + 1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_inst_valid();
    check("rd_hold_pc", inst_pc, 32'h8000_0100);
    exp_req_q.push_back(32'h8000_0040);
    exp_inst_q.push_back(32'h8000_0040);
    resp_delay = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    base = n_acc;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd_hold_count", fetch_count, 32'd6);
    check("rd_hold_addr", imem_req_addr, 32'h8000_0040);
    check("rd_hold_req", 32'(imem_req_valid), 32'd1);
    wait_acc(base + 1);
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    check("rd_count", fetch_count, 32'd7);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("wrap_idle_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_idle_req", 32'(imem_req_valid), 32'd0);
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_inst_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000);
    exp_inst_q.push_back(32'h0000_0000);
    fetch_en = 1'b1;
    base = n_acc;
    wait_acc(base + 2);
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    check("wrap_count", fetch_count, 32'd9);
    check("wrap_pc", imem_req_addr, 32'h0000_0004);

    // Misaligned redirect: sticky fault, inputs ignored, only reset recovers
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; fetch_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("flt_fault", 32'(fetch_fault), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("flt_sticky", 32'(fetch_fault), 32'd1);
      check("flt_no_req", 32'(imem_req_valid), 32'd0);
      check("flt_pc", imem_req_addr, 32'h0000_0004);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flt_ignore_rd", imem_req_addr, 32'h0000_0004);
    check("flt_ignore_flag", 32'(fetch_fault), 32'd1);
    rst = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    check("rec_fault", 32'(fetch_fault), 32'd0);
    check("rec_pc", imem_req_addr, 32'h8000_0000);
    check("rec_count", fetch_count, 32'd0);
    check("rec_inst_valid", 32'(inst_valid), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_req_left", 32'(exp_req_q.size()), 32'd0);
    check("sb_inst_left", 32'(exp_inst_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
